// File: rtl/im.sv
// Instruction ROM: DEPTH fixed 32-bit words, byte-addressed, 1-cycle registered read.
// Addresses beyond the ROM read as zero; reset clears the output register only.
module im #(
   parameter int DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] address,
   output logic [31:0] instruction
);

   localparam int AW = $clog2(DEPTH);

   typedef logic [DEPTH-1:0][31:0] rom_t;

   // Program image; everything past the first eight words stays zero.
   function automatic rom_t rom_init();
      rom_t r;
      r    = '0;
      r[0] = 32'h20010005;
      r[1] = 32'h2002000A;
      r[2] = 32'h00221820;
      r[3] = 32'hAC030000;
      r[4] = 32'h8C040000;
      r[5] = 32'h10640001;
      r[6] = 32'h00000000;
      r[7] = 32'h08000000;
      return r;
   endfunction

   localparam rom_t ROM = rom_init();

   logic [AW-1:0] idx;
   logic          oor;
   logic [31:0]   rd;
   logic          unused_ok;

   assign idx       = address[AW+1:2];
   assign oor       = |address[31:AW+2];
   assign rd        = oor ? 32'h0 : ROM[idx];
   // Byte offset within a word is irrelevant to a word fetch.
   assign unused_ok = &{1'b0, address[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) instruction <= 32'h0;
      else        instruction <= rd;
   end

endmodule

// File: tb/tb_im.sv
// Self-checking bench for im: directed scenarios plus randomized back-to-back
// fetches compared against a table-driven reference model.
module tb_im;

   localparam int DEPTH = 64;
   localparam int AW    = $clog2(DEPTH);

   logic        clk;
   logic        rst_n;
   logic [31:0] address;
   logic [31:0] instruction;

   int checks;
   int passes;

   logic [31:0] prog [0:7];

   im #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .address    (address),
      .instruction(instruction)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: address decoded with plain arithmetic from the memory map.
   function automatic logic [31:0] ref_word(input logic [31:0] a);
      int unsigned w;
      if ((a >> (AW + 2)) != 0) return 32'h0;
      w = a / 4;
      if (w < 8) return prog[w];
      return 32'h0;
   endfunction

   // Every task starts and ends 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      address = 32'h0;
      #3;
      checks++;
      if (instruction !== 32'h0) $display("FAIL reset_t0 got %h want %h", instruction, 32'h0);
      else passes++;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (instruction !== 32'h0) $display("FAIL reset_hold%0d got %h want %h", i, instruction, 32'h0);
         else passes++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (instruction !== 32'h20010005) $display("FAIL reset_release got %h want %h", instruction, 32'h20010005);
      else passes++;
   endtask

   task automatic test_sequential();
      logic [31:0] exp;
      for (int i = 0; i < 4; i++) begin
         address = 32'(i * 4);
         exp     = ref_word(address);
         tick();
         checks++;
         if (instruction !== exp) $display("FAIL seq_addr%0h got %h want %h", i * 4, instruction, exp);
         else passes++;
      end
      checks++;
      if (exp !== 32'hAC030000) $display("FAIL seq_model got %h want %h", exp, 32'hAC030000);
      else passes++;
   endtask

   task automatic test_unaligned();
      logic [31:0] al [0:3];
      logic [31:0] ex [0:3];
      al[0] = 32'h5; al[1] = 32'h6; al[2] = 32'h7; al[3] = 32'h1C;
      ex[0] = 32'h2002000A; ex[1] = 32'h2002000A; ex[2] = 32'h2002000A; ex[3] = 32'h08000000;
      for (int i = 0; i < 4; i++) begin
         address = al[i];
         tick();
         checks++;
         if (instruction !== ex[i]) $display("FAIL unaligned_%h got %h want %h", al[i], instruction, ex[i]);
         else passes++;
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] al [0:4];
      al[0] = 32'h1C; al[1] = 32'h20; al[2] = 32'h100; al[3] = 32'hFFFFFFFC; al[4] = 32'h0FC;
      for (int i = 0; i < 5; i++) begin
         address = al[i];
         tick();
         checks++;
         if (instruction !== ref_word(al[i]))
            $display("FAIL range_%h got %h want %h", al[i], instruction, ref_word(al[i]));
         else passes++;
      end
      // 0x100 aliases word 0 if the upper bits were dropped.
      address = 32'h100;
      tick();
      checks++;
      if (instruction !== 32'h0) $display("FAIL range_alias got %h want %h", instruction, 32'h0);
      else passes++;
   endtask

   task automatic test_midcycle_change();
      address = 32'h0;
      tick();
      checks++;
      if (instruction !== 32'h20010005) $display("FAIL mid_first got %h want %h", instruction, 32'h20010005);
      else passes++;
      @(negedge clk);
      address = 32'h10;
      #1;
      checks++;
      if (instruction !== 32'h20010005) $display("FAIL mid_hold got %h want %h", instruction, 32'h20010005);
      else passes++;
      tick();
      checks++;
      if (instruction !== 32'h8C040000) $display("FAIL mid_next got %h want %h", instruction, 32'h8C040000);
      else passes++;
   endtask

   task automatic test_async_reset();
      address = 32'h8;
      tick();
      checks++;
      if (instruction !== 32'h00221820) $display("FAIL arst_pre got %h want %h", instruction, 32'h00221820);
      else passes++;
      address = 32'hC;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (instruction !== 32'h0) $display("FAIL arst_async got %h want %h", instruction, 32'h0);
      else passes++;
      tick();
      checks++;
      if (instruction !== 32'h0) $display("FAIL arst_discard got %h want %h", instruction, 32'h0);
      else passes++;
      @(negedge clk);
      rst_n   = 1'b1;
      address = 32'h4;
      tick();
      checks++;
      if (instruction !== 32'h2002000A) $display("FAIL arst_release got %h want %h", instruction, 32'h2002000A);
      else passes++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      int          errs;
      errs = 0;
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0:       a = $urandom();
            1:       a = $urandom_range(0, 31);
            default: a = $urandom_range(0, DEPTH * 4 + 64);
         endcase
         address = a;
         tick();
         checks++;
         if (instruction !== ref_word(a)) begin
            errs++;
            if (errs <= 10)
               $display("FAIL rand_%0d addr %h got %h want %h", i, a, instruction, ref_word(a));
         end
         else passes++;
      end
   endtask

   initial begin
      checks = 0;
      passes = 0;
      prog[0] = 32'h20010005; prog[1] = 32'h2002000A;
      prog[2] = 32'h00221820; prog[3] = 32'hAC030000;
      prog[4] = 32'h8C040000; prog[5] = 32'h10640001;
      prog[6] = 32'h00000000; prog[7] = 32'h08000000;
      test_reset();
      test_sequential();
      test_unaligned();
      test_out_of_range();
      test_midcycle_change();
      test_async_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
